// File: rtl/chunk_serial_adder.sv
// Multi-cycle add/subtract, CHUNK bits per clock, valid/ready on both sides.
// Optional saturation on signed overflow: define ADDER_SAT_EN.
module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_chunk_chk
    $error("CHUNK must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic [WIDTH-1:0] sum_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [CHUNK:0]   part;
  logic             ovf_nx;

  assign in_ready = (state == IDLE);

  always_comb begin
    part = {1'b0, opa[cnt*CHUNK +: CHUNK]}
         + {1'b0, opb[cnt*CHUNK +: CHUNK]}
         + (CHUNK+1)'(carry);
    res_nx = res;
    res_nx[cnt*CHUNK +: CHUNK] = part[CHUNK-1:0];
    ovf_nx = (opa[WIDTH-1] == opb[WIDTH-1])
          && (res_nx[WIDTH-1] != opa[WIDTH-1]);
`ifdef ADDER_SAT_EN
    if (ovf_nx)
      sum_nx = opa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sum_nx = res_nx;
`else
    sum_nx = res_nx;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      res       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= res_nx;
          carry <= part[CHUNK];
          cnt   <= cnt + CW'(1);
          // results only become visible once every slice is done
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= sum_nx;
            cout      <= part[CHUNK];
            ovf       <= ovf_nx;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Bench for chunk_serial_adder: scoreboard of expected results,
// directed ops on a CHUNK=4 and a CHUNK=16 instance.
module tb_chunk_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  logic        in_valid2, in_ready2, sub2, out_valid2, out_ready2;
  logic        cout2, ovf2;
  logic [15:0] a2, b2, sum2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;

  always #5 clk = ~clk;

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .sub(sub2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_,
                                 input logic ts);
    exp_t e;
    int   sa, sbv, t, ua, ub;
    sa  = $signed(ta);
    sbv = $signed(tb_);
    ua  = int'(ta);
    ub  = int'(tb_);
    t   = ts ? sa - sbv : sa + sbv;
    e.o = (t > 32767) || (t < -32768);
    e.s = t[15:0];
    e.c = ts ? (ua >= ub) : ((ua + ub) > 65535);
`ifdef ADDER_SAT_EN
    if (e.o) e.s = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_,
                          input logic ts);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_wait", 32'(w < 20), 32'd1);
    a = ta; b = tb_; sub = ts; in_valid = 1'b1;
    sb.push_back(model(ta, tb_, ts));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_result(input string tag, input int lat);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      last_e = sb.pop_front();
      check({tag, "_sum"}, 32'(sum), 32'(last_e.s));
      check({tag, "_cout"}, 32'(cout), 32'(last_e.c));
      check({tag, "_ovf"}, 32'(ovf), 32'(last_e.o));
    end
  endtask

  task automatic finish_hs(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_vdrop"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] ta,
                       input logic [15:0] tb_, input logic ts);
    start_op(ta, tb_, ts);
    wait_result(tag, 4);
    finish_hs(tag);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("t1", 16'h1234, 16'h4321, 1'b0);
    check("t1_const", 32'(last_e.s), 32'h5555);
    do_op("t2", 16'hFFFF, 16'h0001, 1'b0);
    do_op("t3", 16'h7FFF, 16'h0001, 1'b0);
    do_op("t4a", 16'h0005, 16'h0007, 1'b1);
    do_op("t4b", 16'h8000, 16'h0001, 1'b1);
    for (int i = 0; i < 4; i++)
      do_op("rnd", 16'($urandom), 16'($urandom), 1'($urandom));

    // hold in DONE with out_ready low, in_valid pulsed
    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_result("t5", 4);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      check("t5_valid", 32'(out_valid), 32'd1);
      check("t5_rdy", 32'(in_ready), 32'd0);
      check("t5_sum", 32'(sum), 32'(last_e.s));
      check("t5_cout", 32'(cout), 32'(last_e.c));
      check("t5_ovf", 32'(ovf), 32'(last_e.o));
    end
    in_valid = 1'b0;
    finish_hs("t5");
    @(posedge clk); #1;
    check("t5_nosecond", 32'(out_valid), 32'd0);
    check("t5_keep", 32'(sum), 32'(last_e.s));

    // reset mid-run at cnt=2
    start_op(16'hABCD, 16'h1111, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    void'(sb.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_sum", 32'(sum), 32'd0);
    check("t6_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    do_op("t6_next", 16'h0003, 16'h0004, 1'b0);
    check("t6_const", 32'(last_e.s), 32'h0007);

    // CHUNK=16 instance: latency 1
    a2 = 16'h1234; b2 = 16'h4321; sub2 = 1'b0; in_valid2 = 1'b1;
    sb.push_back(model(16'h1234, 16'h4321, 1'b0));
    @(posedge clk); #1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0;
    cyc = 0;
    while (!out_valid2 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check("c16_lat", 32'(cyc), 32'd1);
    last_e = sb.pop_front();
    check("c16_sum", 32'(sum2), 32'(last_e.s));
    check("c16_cout", 32'(cout2), 32'(last_e.c));
    check("c16_ovf", 32'(ovf2), 32'(last_e.o));
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    check("c16_vdrop", 32'(out_valid2), 32'd0);
    check("c16_rdy", 32'(in_ready2), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
